// File: rtl/zx_pixel_pipe.sv
// Spectrum 256x192 screen renderer for a 640x480 beam: video RAM fetch, attribute decode, border, flash.
// Fixed 4-clock input-to-output latency; sync/DE/border ride a matched shift chain, no backpressure.
module zx_pixel_pipe #(
  parameter int H_OFFSET = 64,
  parameter int V_OFFSET = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [2:0]  border,
  output logic [12:0] vid_addr,
  input  logic [7:0]  vid_data,
  output logic [12:0] attr_addr,
  input  logic [7:0]  attr_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_de,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int LAT = 4;

  localparam logic [9:0] H_LO = 10'(H_OFFSET);
  localparam logic [9:0] H_HI = 10'(H_OFFSET + 511);
  localparam logic [9:0] V_LO = 10'(V_OFFSET);
  localparam logic [9:0] V_HI = 10'(V_OFFSET + 383);

  // Sync chain entry order: {de, hs, vs}; index 0 is S0, index LAT-1 is the output register.
  logic [2:0]  sync_q [LAT];
  logic [2:0]  sync_d [LAT];

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [2:0]  border_s0_q, border_s0_d;
  logic [2:0]  border_s1_q, border_s1_d;
  logic [2:0]  border_s2_q, border_s2_d;

  logic [4:0]  frame_q, frame_d;

  logic [12:0] vid_addr_q, vid_addr_d;
  logic [12:0] attr_addr_q, attr_addr_d;
  logic        in_scr_s1_q, in_scr_s1_d;
  logic        in_scr_s2_q, in_scr_s2_d;
  logic [2:0]  pxlo_s1_q, pxlo_s1_d;
  logic [2:0]  pxlo_s2_q, pxlo_s2_d;

  logic [3:0]  r_q, r_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  b_q, b_d;

  logic [9:0]  hrel;
  logic [9:0]  vrel;
  logic [7:0]  px;
  logic [7:0]  py;
  logic        in_scr;

  logic [2:0]  ink;
  logic [2:0]  paper;
  logic [2:0]  colour;
  logic        bright;
  logic        pixel;
  logic        de_s2;

  function automatic logic [3:0] level(input logic on, input logic hi);
    if (!on) begin
      return 4'h0;
    end
    return hi ? 4'hF : 4'hC;
  endfunction

  // S0: input capture and flash frame counter
  always_comb begin
    hcount_d    = hcount;
    vcount_d    = vcount;
    border_s0_d = border;
    frame_d     = frame_q;
    if (vs_in && !sync_q[0][0]) begin
      frame_d = frame_q + 5'd1;
    end
  end

  always_comb begin
    sync_d[0] = {de_in, hs_in, vs_in};
    for (int i = 1; i < LAT; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // S1: geometry and video RAM addressing
  always_comb begin
    hrel   = hcount_q - H_LO;
    vrel   = vcount_q - V_LO;
    px     = hrel[8:1];
    py     = vrel[8:1];
    in_scr = (hcount_q >= H_LO) && (hcount_q <= H_HI) &&
             (vcount_q >= V_LO) && (vcount_q <= V_HI);
  end

  always_comb begin
    vid_addr_d  = vid_addr_q;
    attr_addr_d = attr_addr_q;
    if (in_scr) begin
      vid_addr_d  = {py[7:6], py[2:0], py[5:3], px[7:3]};
      attr_addr_d = 13'h1800 + {3'b000, py[7:3], px[7:3]};
    end
    in_scr_s1_d = in_scr;
    pxlo_s1_d   = px[2:0];
    border_s1_d = border_s0_q;
  end

  // S2: wait for RAM data alongside the control bits
  always_comb begin
    in_scr_s2_d = in_scr_s1_q;
    pxlo_s2_d   = pxlo_s1_q;
    border_s2_d = border_s1_q;
  end

  // S3: attribute decode and colour select
  always_comb begin
    ink    = attr_data[2:0];
    paper  = attr_data[5:3];
    if (attr_data[7] && frame_q[4]) begin
      ink   = attr_data[5:3];
      paper = attr_data[2:0];
    end
    pixel  = vid_data[3'd7 - pxlo_s2_q];
    de_s2  = sync_q[2][2];
    colour = 3'b000;
    bright = 1'b0;
    if (de_s2) begin
      if (in_scr_s2_q) begin
        colour = pixel ? ink : paper;
        bright = attr_data[6];
      end else begin
        colour = border_s2_q;
      end
    end
    g_d = level(colour[2], bright);
    r_d = level(colour[1], bright);
    b_d = level(colour[0], bright);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      border_s0_q <= '0;
      border_s1_q <= '0;
      border_s2_q <= '0;
      frame_q     <= '0;
      vid_addr_q  <= '0;
      attr_addr_q <= '0;
      in_scr_s1_q <= 1'b0;
      in_scr_s2_q <= 1'b0;
      pxlo_s1_q   <= '0;
      pxlo_s2_q   <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      for (int i = 0; i < LAT; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      border_s0_q <= border_s0_d;
      border_s1_q <= border_s1_d;
      border_s2_q <= border_s2_d;
      frame_q     <= frame_d;
      vid_addr_q  <= vid_addr_d;
      attr_addr_q <= attr_addr_d;
      in_scr_s1_q <= in_scr_s1_d;
      in_scr_s2_q <= in_scr_s2_d;
      pxlo_s1_q   <= pxlo_s1_d;
      pxlo_s2_q   <= pxlo_s2_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      for (int i = 0; i < LAT; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign vid_addr  = vid_addr_q;
  assign attr_addr = attr_addr_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign vga_de    = sync_q[LAT-1][2];
  assign vga_hs    = sync_q[LAT-1][1];
  assign vga_vs    = sync_q[LAT-1][0];

endmodule

// File: tb/tb_zx_pixel_pipe.sv
// Directed bench for zx_pixel_pipe: reset, addressing, pixel/attribute decode, flash, border, sync delay.
module tb_zx_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [2:0]  border;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic [12:0] attr_addr;
  logic [7:0]  attr_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_de;
  logic        vga_hs;
  logic        vga_vs;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  zx_pixel_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .border    (border),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .attr_addr (attr_addr),
    .attr_data (attr_data),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_de    (vga_de),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    hcount = 10'd10; vcount = 10'd10; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b0;
    border = 3'b111; vid_data = 8'h00; attr_data = 8'h00; reset = 1'b0;
    step(5);
    n_checks++;
    if ({vga_r, vga_g, vga_b, vga_de, vga_hs} !== {12'hCCC, 2'b11}) begin
      n_fail++;
      $display("FAIL pre_reset_active: got rgb=%h de=%b hs=%b, want rgb=ccc de=1 hs=1",
               {vga_r, vga_g, vga_b}, vga_de, vga_hs);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++;
      if ({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, vid_addr, attr_addr} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got rgb=%h de=%b hs=%b vs=%b va=%h aa=%h, want all 0",
                 i, {vga_r, vga_g, vga_b}, vga_de, vga_hs, vga_vs, vid_addr, attr_addr);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      n_checks++;
      if (i < 4 && {vga_r, vga_g, vga_b, vga_de, vga_hs} !== '0) begin
        n_fail++;
        $display("FAIL reset_refill clk %0d: got rgb=%h de=%b hs=%b, want 0", i,
                 {vga_r, vga_g, vga_b}, vga_de, vga_hs);
      end else if (i == 4 && {vga_r, vga_g, vga_b, vga_de, vga_hs} !== {12'hCCC, 2'b11}) begin
        n_fail++;
        $display("FAIL reset_first_valid: got rgb=%h de=%b hs=%b, want ccc 1 1",
                 {vga_r, vga_g, vga_b}, vga_de, vga_hs);
      end
    end
  endtask

  task automatic test_addressing;
    logic [9:0]  h_tab  [5] = '{10'd82,   10'd575,  10'd10,   10'd576,  10'd64};
    logic [9:0]  v_tab  [5] = '{10'd202,  10'd431,  10'd202,  10'd100,  10'd48};
    logic [12:0] va_tab [5] = '{13'h0D21, 13'h17FF, 13'h17FF, 13'h17FF, 13'h0000};
    logic [12:0] aa_tab [5] = '{13'h1921, 13'h1AFF, 13'h1AFF, 13'h1AFF, 13'h1800};
    de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hcount = h_tab[i];
      vcount = v_tab[i];
      step(2);
      n_checks++;
      if (vid_addr !== va_tab[i] || attr_addr !== aa_tab[i]) begin
        n_fail++;
        $display("FAIL addr vec %0d (h=%0d v=%0d): got va=%h aa=%h, want va=%h aa=%h",
                 i, h_tab[i], v_tab[i], vid_addr, attr_addr, va_tab[i], aa_tab[i]);
      end
    end
  endtask

  task automatic test_pixel_attr;
    logic [9:0]  h_tab   [4] = '{10'd64,   10'd65,   10'd66,   10'd63};
    logic [11:0] rgb_tab [4] = '{12'hFFF,  12'hFFF,  12'h000,  12'h0CC};
    vid_data = 8'h80; attr_data = 8'h47; border = 3'b101;
    vcount = 10'd100; de_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hcount = h_tab[i];
      step(4);
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== rgb_tab[i]) begin
        n_fail++;
        $display("FAIL pixel_attr h=%0d: got rgb=%h, want %h", h_tab[i],
                 {vga_r, vga_g, vga_b}, rgb_tab[i]);
      end
    end
  endtask

  task automatic test_flash;
    logic [11:0] want;
    reset = 1'b1; vs_in = 1'b0;
    step(1);
    reset = 1'b0;
    vid_data = 8'hFF; attr_data = 8'h87;
    hcount = 10'd100; vcount = 10'd100; de_in = 1'b1;
    step(4);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 12'hCCC) begin
      n_fail++;
      $display("FAIL flash_start: got rgb=%h, want ccc", {vga_r, vga_g, vga_b});
    end
    for (int n = 1; n <= 32; n++) begin
      vs_in = 1'b1;
      step(1);
      vs_in = 1'b0;
      step(1);
      if (n == 15 || n == 16 || n == 31 || n == 32) begin
        want = (n == 16 || n == 31) ? 12'h000 : 12'hCCC;
        step(4);
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== want) begin
          n_fail++;
          $display("FAIL flash after %0d edges: got rgb=%h, want %h", n,
                   {vga_r, vga_g, vga_b}, want);
        end
      end
    end
  endtask

  task automatic test_border;
    hcount = 10'd10; vcount = 10'd100; de_in = 1'b1; border = 3'b010;
    step(4);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 12'hC00) begin
      n_fail++;
      $display("FAIL border_red: got rgb=%h, want c00", {vga_r, vga_g, vga_b});
    end
    de_in = 1'b0;
    step(4);
    n_checks++;
    if ({vga_r, vga_g, vga_b, vga_de} !== 13'h0) begin
      n_fail++;
      $display("FAIL border_blank: got rgb=%h de=%b, want 000 0", {vga_r, vga_g, vga_b}, vga_de);
    end
    de_in = 1'b1;
    step(4);
    border = 3'b100;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== ((i < 4) ? 12'hC00 : 12'h0C0)) begin
        n_fail++;
        $display("FAIL border_toggle clk %0d: got rgb=%h, want %h", i, {vga_r, vga_g, vga_b},
                 (i < 4) ? 12'hC00 : 12'h0C0);
      end
    end
  endtask

  task automatic test_sync;
    logic [2:0] hist [$];
    logic [2:0] v;
    hcount = 10'd5; vcount = 10'd5; border = 3'b000;
    for (int j = 0; j < 48; j++) begin
      v = 3'($urandom_range(0, 7));
      {de_in, hs_in, vs_in} = v;
      hist.push_back(v);
      step(1);
      if (j >= 3) begin
        n_checks++;
        if ({vga_de, vga_hs, vga_vs} !== hist[j-3]) begin
          n_fail++;
          $display("FAIL sync_delay cycle %0d: got de/hs/vs=%b, want %b", j,
                   {vga_de, vga_hs, vga_vs}, hist[j-3]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    border = '0; vid_data = '0; attr_data = '0;
    step(2);
    test_reset();
    test_addressing();
    test_pixel_attr();
    test_flash();
    test_border();
    test_sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
